mem_req_tracker: RTL

MEM_REQ_TRACKER -- requirements
Module: mem_req_tracker

---
 rtl/mem_req_tracker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_req_tracker.sv
// mem_req_tracker: allocates AXI IDs to block memory requests, remembers the
// requester tag and read/write kind per ID, and routes the response back to
// the requester one cycle after the adapter returns it.
//
// Handshake semantics: a request transfers on a cycle where
// in_req_valid_i & in_ready_o. mem_req_valid_o never looks at mem_ready_i,
// so the same cycle is also the mem_req_valid_o & mem_ready_i transfer
// toward the adapter. Responses have no back-pressure on either side:
// mem_rsp_valid_i is consumed the cycle it is seen, and out_rsp_valid_o is
// a single-cycle pulse that the requester must take.
module mem_req_tracker #(
  parameter int unsigned NumIds = 4,
  parameter type req_tag_t    = logic,
  parameter type req_id_t     = logic,
  parameter type block_addr_t = logic,
  parameter type block_mask_t = logic,
  parameter type block_data_t = logic
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    in_ready_o,
  input  logic                    in_req_valid_i,
  input  req_tag_t                in_req_tag_i,
  input  block_addr_t             in_req_addr_i,
  input  block_mask_t             in_req_we_mask_i,
  input  block_data_t             in_req_wdata_i,
  input  logic                    mem_ready_i,
  output logic                    mem_req_valid_o,
  output req_id_t                 mem_req_id_o,
  output block_addr_t             mem_req_addr_o,
  output block_mask_t             mem_req_we_mask_o,
  output block_data_t             mem_req_wdata_o,
  input  logic                    mem_rsp_valid_i,
  input  req_id_t                 mem_rsp_id_i,
  input  block_data_t             mem_rsp_data_i,
  output logic                    out_rsp_valid_o,
  output req_tag_t                out_rsp_tag_o,
  output logic                    out_rsp_write_o,
  output block_data_t             out_rsp_data_o,
  output logic [$clog2(NumIds):0] outstanding_o,
  output logic                    err_o
);

  localparam int unsigned IdW  = $clog2(NumIds);
  localparam int unsigned CntW = IdW + 1;

  // Per-ID state: busy bitmap and the {tag, is_write} table.
  logic [NumIds-1:0] busy_q, busy_d;
  req_tag_t          tag_q [NumIds];
  logic [NumIds-1:0] is_write_q;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              rsp_valid_q;
  req_tag_t          rsp_tag_q;
  logic              rsp_write_q;
  block_data_t       rsp_data_q;

  logic              any_free;
  logic [IdW-1:0]    alloc_idx;
  logic [IdW-1:0]    rsp_idx;
  logic              alloc_fire;
  logic              rsp_hit;
  logic              rsp_miss;

  // Lowest-index free ID; scanning downward lets the lowest one win.
  always_comb begin
    alloc_idx = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IdW'(i);
    end
  end

  assign any_free   = |(~busy_q);
  assign rsp_idx    = IdW'(mem_rsp_id_i);
  assign alloc_fire = in_req_valid_i & in_ready_o;
  assign rsp_hit    = mem_rsp_valid_i & busy_q[rsp_idx];
  assign rsp_miss   = mem_rsp_valid_i & ~busy_q[rsp_idx];

  // Request path is purely combinational; payload passes straight through.
  always_comb begin
    mem_req_valid_o   = in_req_valid_i & any_free;
    in_ready_o        = mem_ready_i & any_free;
    mem_req_id_o      = req_id_t'(alloc_idx);
    mem_req_addr_o    = in_req_addr_i;
    mem_req_we_mask_o = in_req_we_mask_i;
    mem_req_wdata_o   = in_req_wdata_i;
  end

  // Next busy map, outstanding count and sticky error. An allocation and a
  // free in the same cycle always hit different IDs, since only a free ID
  // is allocated and only a busy ID is freed.
  always_comb begin
    busy_d = busy_q;
    if (alloc_fire) busy_d[alloc_idx] = 1'b1;
    if (rsp_hit)    busy_d[rsp_idx]   = 1'b0;

    cnt_d = cnt_q;
    case ({alloc_fire, rsp_hit})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q | rsp_miss;
  end

  // Tracking state and the per-ID table, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      is_write_q <= '0;
      for (int i = 0; i < int'(NumIds); i++) tag_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      if (alloc_fire) begin
        tag_q[alloc_idx]      <= in_req_tag_i;
        is_write_q[alloc_idx] <= |in_req_we_mask_i;
      end
    end
  end

  // Response register: one-cycle pulse carrying the stored tag and kind;
  // write responses return zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_hit;
      if (rsp_hit) begin
        rsp_tag_q   <= tag_q[rsp_idx];
        rsp_write_q <= is_write_q[rsp_idx];
        rsp_data_q  <= is_write_q[rsp_idx] ? '0 : mem_rsp_data_i;
      end
    end
  end

  assign out_rsp_valid_o = rsp_valid_q;
  assign out_rsp_tag_o   = rsp_tag_q;
  assign out_rsp_write_o = rsp_write_q;
  assign out_rsp_data_o  = rsp_data_q;
  assign outstanding_o   = cnt_q;
  assign err_o           = err_q;

endmodule
